genius_controller: RTL and testbench

Game sequencer for the Genius (Simon) game. Drives the address of the 16-entry colour-sequence ROM and plays the first N colours on the LEDs, then checks the player's button presses against the same ROM entries. On a correct round it advances N, up to MAX_LEVEL. It reports win/lose and sits between the debounced button inputs, the sequence ROM and the LED/score outputs.

---
 rtl/genius_controller.sv | 162 ++++++++++++++++
 tb/tb_genius_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_controller.sv
// Genius (Simon) game sequencer: plays back the first N ROM colours on the LEDs,
// then checks the player's presses against the same ROM entries, advancing N up to MAX_LEVEL.
module genius_controller #(
    parameter int unsigned LED_ON_CYCLES  = 12_500_000,
    parameter int unsigned LED_OFF_CYCLES = 6_250_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned MAX_LEVEL      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] buttons,
    input  logic [3:0] seq_data,
    output logic [3:0] seq_addr,
    output logic [3:0] leds,
    output logic [4:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int unsigned CNT_W = 27;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned LVL_W = 5;
    localparam int unsigned BTN_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_ROUND_GAP,
        S_WIN,
        S_LOSE
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [LVL_W-1:0]   level_q, level_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BTN_W-1:0]   btn_prev;
    logic [BTN_W-1:0]   held, held_n;

    logic press;
    logic match;
    logic last_idx;
    logic on_done;
    logic off_done;
    logic timeout_hit;

    // Edge-qualified press: a held button only counts again after a full release.
    assign press       = (buttons != BTN_W'(0)) && (btn_prev == BTN_W'(0));
    assign match       = $onehot(buttons) && (buttons == seq_data);
    assign last_idx    = ({1'b0, idx} == (level_q - LVL_W'(1)));
    assign on_done     = (cnt == CNT_W'(LED_ON_CYCLES - 1));
    assign off_done    = (cnt == CNT_W'(LED_OFF_CYCLES - 1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            level_q  <= '0;
            cnt      <= '0;
            btn_prev <= '0;
            held     <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            level_q  <= level_n;
            cnt      <= cnt_n;
            btn_prev <= buttons;
            held     <= held_n;
        end
    end

    // Next-state logic; start overrides everything, including a coincident press or timeout.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        level_n = level_q;
        held_n  = held;

        if (start) begin
            level_n = LVL_W'(1);
            idx_n   = '0;
            state_n = S_SHOW_ON;
        end else begin
            case (state)
                S_SHOW_ON: begin
                    if (on_done) begin
                        state_n = S_SHOW_OFF;
                    end
                end
                S_SHOW_OFF: begin
                    if (off_done) begin
                        if (last_idx) begin
                            idx_n   = '0;
                            state_n = S_WAIT_PRESS;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = S_SHOW_ON;
                        end
                    end
                end
                S_WAIT_PRESS: begin
                    if (press) begin
                        held_n  = buttons;
                        state_n = match ? S_WAIT_RELEASE : S_LOSE;
                    end else if (timeout_hit) begin
                        state_n = S_LOSE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (buttons == BTN_W'(0)) begin
                        if (!last_idx) begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = S_WAIT_PRESS;
                        end else if (level_q == LVL_W'(MAX_LEVEL)) begin
                            state_n = S_WIN;
                        end else begin
                            level_n = level_q + LVL_W'(1);
                            idx_n   = '0;
                            state_n = S_ROUND_GAP;
                        end
                    end
                end
                S_ROUND_GAP: begin
                    if (off_done) begin
                        state_n = S_SHOW_ON;
                    end
                end
                default: begin
                end
            endcase
        end

        cnt_n = (start || (state_n != state)) ? '0 : cnt + CNT_W'(1);
    end

    // Output decode from the registered state.
    always_comb begin
        leds = '0;
        busy = 1'b0;
        win  = 1'b0;
        lose = 1'b0;
        case (state)
            S_SHOW_ON:      leds = seq_data;
            S_WAIT_RELEASE: leds = held;
            S_WIN:          leds = 4'b1111;
            default:        leds = '0;
        endcase
        busy = (state != S_IDLE) && (state != S_WIN) && (state != S_LOSE);
        win  = (state == S_WIN);
        lose = (state == S_LOSE);
    end

    assign seq_addr = idx;
    assign level    = level_q;

endmodule

// File: tb/tb_genius_controller.sv
// Scoreboarded bench for genius_controller: a game-level player model pushes the expected
// per-cycle outputs, a monitor pops and compares them on every falling edge.
module tb_genius_controller;

    localparam int unsigned ON   = 3;
    localparam int unsigned OFF  = 2;
    localparam int unsigned TO   = 20;
    localparam int unsigned MAXL = 2;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] addr;
        logic [4:0] level;
        logic       busy;
        logic       win;
        logic       lose;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] buttons;
    logic [3:0] seq_data;
    logic [3:0] seq_addr;
    logic [3:0] leds;
    logic [4:0] level;
    logic       busy, win, lose;

    logic       rst_nt;
    logic       start_nt;
    logic [3:0] buttons_nt;
    logic [3:0] seq_data_nt;
    logic [3:0] seq_addr_nt;
    logic [3:0] leds_nt;
    logic [4:0] level_nt;
    logic       busy_nt, win_nt, lose_nt;

    logic [3:0] rom [16];

    int   checks   = 0;
    int   failures = 0;
    bit   nt_done  = 1'b0;

    obs_t       q[$];
    int         mq[$];
    int         aq[$];
    obs_t       cur;
    int         m_level;
    int         m_idx;
    logic [3:0] prev_b;
    logic [3:0] held_m;

    always #5 clk = ~clk;

    assign seq_data    = rom[seq_addr];
    assign seq_data_nt = rom[seq_addr_nt];

    genius_controller #(
        .LED_ON_CYCLES (ON),
        .LED_OFF_CYCLES(OFF),
        .TIMEOUT_CYCLES(TO),
        .MAX_LEVEL     (MAXL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .buttons (buttons),
        .seq_data(seq_data),
        .seq_addr(seq_addr),
        .leds    (leds),
        .level   (level),
        .busy    (busy),
        .win     (win),
        .lose    (lose)
    );

    genius_controller #(
        .LED_ON_CYCLES (ON),
        .LED_OFF_CYCLES(OFF),
        .TIMEOUT_CYCLES(0),
        .MAX_LEVEL     (MAXL)
    ) dut_nt (
        .clk     (clk),
        .rst     (rst_nt),
        .start   (start_nt),
        .buttons (buttons_nt),
        .seq_data(seq_data_nt),
        .seq_addr(seq_addr_nt),
        .leds    (leds_nt),
        .level   (level_nt),
        .busy    (busy_nt),
        .win     (win_nt),
        .lose    (lose_nt)
    );

    function automatic obs_t mk(input logic [3:0] l, input int a, input int lv,
                                input logic bz, input logic w, input logic ls);
        obs_t o;
        o = {l, 4'(a), 5'(lv), bz, w, ls};
        return o;
    endfunction

    function automatic obs_t act_main();
        obs_t o;
        o = {leds, seq_addr, level, busy, win, lose};
        return o;
    endfunction

    function automatic obs_t act_nt();
        obs_t o;
        o = {leds_nt, seq_addr_nt, level_nt, busy_nt, win_nt, lose_nt};
        return o;
    endfunction

    task automatic chk(input string name, input obs_t a, input obs_t x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s @%0t: actual leds=%b addr=%0d level=%0d busy=%b win=%b lose=%b, required leds=%b addr=%0d level=%0d busy=%b win=%b lose=%b",
                     name, $time, a.leds, a.addr, a.level, a.busy, a.win, a.lose,
                     x.leds, x.addr, x.level, x.busy, x.win, x.lose);
        end
    endtask

    // Monitor: every cycle the player model has described is compared here.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("outputs", act_main(), e);
            end
        end
    end

    // One clock of stimulus plus the outputs expected during that clock.
    task automatic cyc(input logic st, input logic [3:0] b, input obs_t e);
        @(posedge clk);
        #1;
        start   = st;
        buttons = b;
        prev_b  = b;
        q.push_back(e);
    endtask

    function automatic logic [3:0] noise();
        if ($urandom_range(0, 1) == 0) return 4'b0000;
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic int pick_mode();
        int r;
        if (mq.size() > 0) return mq.pop_front();
        r = int'($urandom_range(0, 99));
        if (r < 70) return 0;
        if (r < 78) return 1;
        if (r < 82) return 2;
        if (r < 90) return 3;
        if (r < 95) return 4;
        return 5;
    endfunction

    function automatic int pick_abort();
        if (aq.size() > 0) return aq.pop_front();
        if ($urandom_range(0, 7) == 0)
            return int'($urandom_range(0, m_level * int'(ON + OFF) - 1));
        return -1;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, noise(), cur);
    endtask

    // Playback of m_level colours; optionally restarted by start at cycle abort_at.
    task automatic playback(input int abort_at, output bit aborted);
        int   k;
        obs_t e;
        logic [3:0] l;
        aborted = 1'b0;
        k = 0;
        for (int i = 0; i < m_level; i++) begin
            for (int c = 0; c < int'(ON + OFF); c++) begin
                l = (c < int'(ON)) ? rom[i] : 4'b0000;
                e = mk(l, i, m_level, 1'b1, 1'b0, 1'b0);
                if (k == abort_at) begin
                    cyc(1'b1, noise(), e);
                    m_level = 1;
                    m_idx   = 0;
                    aborted = 1'b1;
                    return;
                end
                cyc(1'b0, noise(), e);
                k++;
            end
        end
        m_idx = 0;
    endtask

    // mode: 0 correct, 1 wrong one-hot, 2 multi-bit, 3 no press, 4 start with press, 5 start at timeout.
    // outcome: 0 correct press, 1 lose, 2 restarted.
    task automatic wait_press(input int mode, output int outcome);
        logic [3:0] entry_b, pv, b, pb;
        int   hold_n, delay, start_at;
        obs_t e;
        entry_b = prev_b;
        hold_n  = (entry_b != 4'b0000) ? int'($urandom_range(0, 2)) : 0;
        delay   = int'($urandom_range(1, 8));
        pv      = rom[m_idx];
        if (mode == 1) begin
            pv = 4'b0001 << $urandom_range(0, 3);
            while (pv == rom[m_idx]) pv = 4'b0001 << $urandom_range(0, 3);
        end
        if (mode == 2) pv = rom[m_idx] | {rom[m_idx][2:0], rom[m_idx][3]};
        start_at = (mode == 4) ? hold_n + delay : (mode == 5) ? int'(TO) - 1 : -1;
        outcome = 1;
        for (int c = 0; c < 1000; c++) begin
            if (c < hold_n) b = entry_b;
            else if (c < hold_n + delay || mode == 3 || mode == 5) b = 4'b0000;
            else b = pv;
            e  = mk(4'b0000, m_idx, m_level, 1'b1, 1'b0, 1'b0);
            pb = prev_b;
            if (c == start_at) begin
                cyc(1'b1, b, e);
                m_level = 1;
                m_idx   = 0;
                outcome = 2;
                return;
            end
            cyc(1'b0, b, e);
            if (b != 4'b0000 && pb == 4'b0000) begin
                held_m  = b;
                outcome = (b == rom[m_idx]) ? 0 : 1;
                return;
            end
            if (c == int'(TO) - 1) begin
                outcome = 1;
                return;
            end
        end
    endtask

    // outcome: 0 next press, 1 new round, 2 game won.
    task automatic wait_release(output int outcome);
        int r;
        logic [3:0] b;
        r = int'($urandom_range(0, 3));
        for (int c = 0; c <= r; c++) begin
            b = (c < r) ? (held_m | 4'($urandom_range(0, 15))) : 4'b0000;
            cyc(1'b0, b, mk(held_m, m_idx, m_level, 1'b1, 1'b0, 1'b0));
        end
        if (m_idx != m_level - 1) begin
            m_idx++;
            outcome = 0;
        end else if (m_level == int'(MAXL)) begin
            cur = mk(4'b1111, m_idx, m_level, 1'b0, 1'b1, 1'b0);
            outcome = 2;
        end else begin
            m_level++;
            m_idx   = 0;
            outcome = 1;
        end
    endtask

    task automatic play_game();
        int o;
        bit ab;
        bit in_round;
        cyc(1'b1, 4'b0000, cur);
        m_level = 1;
        m_idx   = 0;
        forever begin
            playback(pick_abort(), ab);
            if (!ab) begin
                in_round = 1'b1;
                while (in_round) begin
                    wait_press(pick_mode(), o);
                    if (o == 2) begin
                        in_round = 1'b0;
                    end else if (o == 1) begin
                        cur = mk(4'b0000, m_idx, m_level, 1'b0, 1'b0, 1'b1);
                        return;
                    end else begin
                        wait_release(o);
                        if (o == 2) return;
                        if (o == 1) begin
                            for (int g = 0; g < int'(OFF); g++)
                                cyc(1'b0, noise(), mk(4'b0000, 0, m_level, 1'b1, 1'b0, 1'b0));
                            in_round = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic reset_in_release();
        int o;
        bit ab;
        cyc(1'b1, 4'b0000, cur);
        m_level = 1;
        m_idx   = 0;
        playback(-1, ab);
        wait_press(0, o);
        cyc(1'b0, held_m, mk(held_m, 0, 1, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", act_main(), mk(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        start   = 1'b0;
        buttons = 4'b0000;
        prev_b  = 4'b0000;
        @(negedge clk);
        rst     = 1'b0;
        cur     = mk(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
        m_level = 0;
        m_idx   = 0;
    endtask

    // Second instance with the timeout disabled: it must wait for a press indefinitely.
    initial begin
        rst_nt     = 1'b1;
        start_nt   = 1'b0;
        buttons_nt = 4'b0000;
        repeat (3) @(negedge clk);
        rst_nt = 1'b0;
        @(posedge clk);
        #1 start_nt = 1'b1;
        @(posedge clk);
        #1 start_nt = 1'b0;
        repeat (int'(ON + OFF) + 1000) @(posedge clk);
        @(negedge clk);
        chk("no_timeout", act_nt(), mk(4'b0000, 0, 1, 1'b1, 1'b0, 1'b0));
        nt_done = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog @%0t: bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b0100;
        for (int i = 2; i < 16; i++) rom[i] = 4'b0001 << $urandom_range(0, 3);
        rst     = 1'b1;
        start   = 1'b0;
        buttons = 4'b0000;
        prev_b  = 4'b0000;
        held_m  = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_state", act_main(), mk(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0));
        rst     = 1'b0;
        cur     = mk(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
        m_level = 0;
        m_idx   = 0;
        idle_cycles(50);

        mq = '{0, 0, 0};
        aq = '{-1, -1};
        play_game();
        idle_cycles(5);

        mq = '{1};
        aq = '{-1};
        play_game();
        idle_cycles(5);

        mq = '{2};
        aq = '{-1};
        play_game();
        idle_cycles(5);

        mq = '{3};
        aq = '{-1};
        play_game();
        idle_cycles(5);

        mq = '{0};
        aq = '{-1, 2, -1};
        play_game();
        idle_cycles(5);

        mq = '{4};
        aq = '{-1, -1};
        play_game();
        idle_cycles(3);

        mq = '{5};
        aq = '{-1, -1};
        play_game();
        idle_cycles(3);

        reset_in_release();
        idle_cycles(5);

        for (int g = 0; g < 25; g++) begin
            play_game();
            idle_cycles(int'($urandom_range(1, 4)));
        end

        for (int i = 0; i < 3000 && !nt_done; i++) @(posedge clk);
        if (!nt_done) begin
            checks++;
            failures++;
            $display("FAIL nt_done: actual done=0 required done=1");
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
